// File: rtl/game_turn_ctrl_pkg.sv
// Shared definitions for the game-control blocks: FSM state encoding, link message type codes,
// the draw LFSR seed and its next-state function.
package game_turn_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInitDraw,
    StSearch,
    StEmit,
    StWaitTurn,
    StMyTurn
  } state_e;

  localparam logic [3:0]  MsgDeckDraw  = 4'd5;
  localparam logic [3:0]  MsgStateTurn = 4'd6;
  localparam logic [15:0] LfsrSeed     = 16'hACE1;

  // Fibonacci LFSR, taps x^16 + x^14 + x^13 + x^11 + 1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
  endfunction

endpackage

// File: rtl/game_turn_ctrl_if.sv
// Inter-board link bundle for game_turn_ctrl.
//   interboard_en/_msg_type/_player : received message strobe, type and target seat
//   send_ready                      : link can take a message this cycle
//   ctrl_en/_msg_type/_card/_player : outgoing message (ctrl_en marks the accepted cycle)
// master = the turn controller, slave = the link transport.
interface game_turn_ctrl_if #(
  parameter int unsigned DECK_SIZE = 106
);
  localparam int unsigned IW = $clog2(DECK_SIZE);

  logic          interboard_en;
  logic [3:0]    interboard_msg_type;
  logic [1:0]    interboard_player;
  logic          send_ready;
  logic          ctrl_en;
  logic [3:0]    ctrl_msg_type;
  logic [IW-1:0] ctrl_card;
  logic [1:0]    ctrl_player;

  modport master (
    input  interboard_en, interboard_msg_type, interboard_player, send_ready,
    output ctrl_en, ctrl_msg_type, ctrl_card, ctrl_player
  );

  modport slave (
    output interboard_en, interboard_msg_type, interboard_player, send_ready,
    input  ctrl_en, ctrl_msg_type, ctrl_card, ctrl_player
  );

endinterface

// File: rtl/deck_picker.sv
// Card search: starting at start_idx, tests one deck index per cycle (wrapping at DECK_SIZE-1)
// until a set bit of avail is found or every index has been visited once.
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : synchronous abort back to idle
//   go         : load start_idx and begin searching
//   avail      : live availability vector, sampled every search cycle
//   done       : one-cycle pulse when the search ends; found/empty say how, index is the hit
module deck_picker #(
  parameter int unsigned DECK_SIZE = 106,
  parameter int unsigned IW        = $clog2(DECK_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 go,
  input  logic [IW-1:0]        start_idx,
  input  logic [DECK_SIZE-1:0] avail,
  output logic                 found,
  output logic [IW-1:0]        index,
  output logic                 empty,
  output logic                 done
);

  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          hit, last;

  assign hit   = avail[idx_q];
  assign last  = (cnt_q == IW'(DECK_SIZE - 1));
  assign found = busy_q & hit;
  assign empty = busy_q & ~hit & last;
  assign done  = busy_q & (hit | last);
  assign index = idx_q;

  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (clear) begin
      idx_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b0;
    end else if (go) begin
      idx_d  = start_idx;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (hit || last) begin
        busy_d = 1'b0;
      end else begin
        idx_d = (idx_q == IW'(DECK_SIZE - 1)) ? '0 : idx_q + IW'(1);
        cnt_d = cnt_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/game_turn_ctrl.sv
// Turn controller for one board in a ring of NUM_PLAYERS boards. Runs the initial deal,
// waits for the turn token, lets the local player finish or draw-and-pass, and emits
// DECK_DRAW / STATE_TURN messages over the link.
//   clk, rst          : clock, asynchronous active-high reset
//   interboard_rst    : synchronous game reset from the remote side (same effect as rst)
//   start_game        : pulse, honoured in idle only
//   done_and_next     : pass the turn (needs rule_valid), honoured in my turn only
//   draw_and_next     : draw one card then pass, honoured in my turn only (wins over done)
//   available_card    : bit i set = card i still in deck
//   link              : inter-board message interface (master side)
//   my_turn, can_done, can_draw, init_phase, deck_empty (sticky) : status
module game_turn_ctrl
  import game_turn_ctrl_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned PLAYER_ID   = 0,
  parameter int unsigned INIT_DRAW   = 14,
  parameter int unsigned DECK_SIZE   = 106
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 interboard_rst,
  input  logic                 start_game,
  input  logic                 done_and_next,
  input  logic                 draw_and_next,
  input  logic                 rule_valid,
  input  logic [DECK_SIZE-1:0] available_card,
  game_turn_ctrl_if.master     link,
  output logic                 my_turn,
  output logic                 can_done,
  output logic                 can_draw,
  output logic                 init_phase,
  output logic                 deck_empty
);

  localparam int unsigned IW       = $clog2(DECK_SIZE);
  localparam int unsigned CW       = $clog2(INIT_DRAW + 1);
  localparam logic [1:0]  MySeat   = 2'(PLAYER_ID);
  localparam logic [1:0]  NextSeat = 2'((PLAYER_ID + 1) % NUM_PLAYERS);
  localparam logic [15:0] Seed     = LfsrSeed ^ 16'(PLAYER_ID);

  state_e        state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [CW-1:0] draw_cnt_q, draw_cnt_d;
  logic          init_phase_q, init_phase_d;
  logic          deck_empty_q, deck_empty_d;
  logic          turn_draw_q, turn_draw_d;   // current draw belongs to a draw_and_next
  logic          my_turn_q, my_turn_d;
  logic [3:0]    msg_type_q, msg_type_d;
  logic [IW-1:0] card_q, card_d;
  logic [1:0]    player_q, player_d;

  logic          pick_go, pick_found, pick_empty, pick_done;
  logic [IW-1:0] pick_start, pick_index;
  logic          emit_fire, turn_msg, load_turn;

  assign pick_start = IW'(32'(lfsr_q) % DECK_SIZE);
  // A sync reset in the same cycle drops the pending message.
  assign emit_fire  = (state_q == StEmit) & link.send_ready & ~interboard_rst;
  assign turn_msg   = link.interboard_en && (link.interboard_msg_type == MsgStateTurn) &&
                      (link.interboard_player == MySeat);

  deck_picker #(
    .DECK_SIZE(DECK_SIZE),
    .IW       (IW)
  ) u_deck_picker (
    .clk      (clk),
    .rst      (rst),
    .clear    (interboard_rst),
    .go       (pick_go),
    .start_idx(pick_start),
    .avail    (available_card),
    .found    (pick_found),
    .index    (pick_index),
    .empty    (pick_empty),
    .done     (pick_done)
  );

  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_next(lfsr_q);
    draw_cnt_d   = draw_cnt_q;
    init_phase_d = init_phase_q;
    deck_empty_d = deck_empty_q;
    turn_draw_d  = turn_draw_q;
    msg_type_d   = msg_type_q;
    card_d       = card_q;
    player_d     = player_q;
    pick_go      = 1'b0;
    load_turn    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_game) begin
          init_phase_d = 1'b1;
          draw_cnt_d   = '0;
          state_d      = (PLAYER_ID == 0) ? StInitDraw : StWaitTurn;
        end
      end
      StInitDraw: begin
        if (32'(draw_cnt_q) < INIT_DRAW) begin
          pick_go    = 1'b1;
          draw_cnt_d = draw_cnt_q + CW'(1);
          state_d    = StSearch;
        end else begin
          load_turn = 1'b1;
          // Seat 0 keeps init_phase until the token comes back around.
          if (PLAYER_ID != 0) init_phase_d = 1'b0;
        end
      end
      StSearch: begin
        if (pick_done && pick_found) begin
          msg_type_d = MsgDeckDraw;
          card_d     = pick_index;
          player_d   = MySeat;
          state_d    = StEmit;
        end else if (pick_done && pick_empty) begin
          // Nothing left: the draw is skipped but the flow continues as if it happened.
          deck_empty_d = 1'b1;
          if (turn_draw_q) load_turn = 1'b1;
          else             state_d   = StInitDraw;
        end
      end
      StEmit: begin
        if (emit_fire) begin
          if (msg_type_q == MsgDeckDraw) begin
            if (turn_draw_q) load_turn = 1'b1;
            else             state_d   = StInitDraw;
          end else begin
            turn_draw_d = 1'b0;
            state_d     = StWaitTurn;
          end
        end
      end
      StWaitTurn: begin
        if (turn_msg) begin
          if (init_phase_q && (PLAYER_ID != 0)) begin
            state_d = StInitDraw;
          end else begin
            init_phase_d = 1'b0;
            state_d      = StMyTurn;
          end
        end
      end
      StMyTurn: begin
        if (draw_and_next) begin
          pick_go     = 1'b1;
          turn_draw_d = 1'b1;
          state_d     = StSearch;
        end else if (done_and_next && rule_valid) begin
          load_turn = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load_turn) begin
      msg_type_d = MsgStateTurn;
      card_d     = '0;
      player_d   = NextSeat;
      state_d    = StEmit;
    end

    if (interboard_rst) begin
      state_d      = StIdle;
      lfsr_d       = Seed;
      draw_cnt_d   = '0;
      init_phase_d = 1'b0;
      deck_empty_d = 1'b0;
      turn_draw_d  = 1'b0;
      msg_type_d   = '0;
      card_d       = '0;
      player_d     = '0;
      pick_go      = 1'b0;
    end

    my_turn_d = (state_d == StMyTurn);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      lfsr_q       <= Seed;
      draw_cnt_q   <= '0;
      init_phase_q <= 1'b0;
      deck_empty_q <= 1'b0;
      turn_draw_q  <= 1'b0;
      my_turn_q    <= 1'b0;
      msg_type_q   <= '0;
      card_q       <= '0;
      player_q     <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      draw_cnt_q   <= draw_cnt_d;
      init_phase_q <= init_phase_d;
      deck_empty_q <= deck_empty_d;
      turn_draw_q  <= turn_draw_d;
      my_turn_q    <= my_turn_d;
      msg_type_q   <= msg_type_d;
      card_q       <= card_d;
      player_q     <= player_d;
    end
  end

  assign link.ctrl_en       = emit_fire;
  assign link.ctrl_msg_type = msg_type_q;
  assign link.ctrl_card     = card_q;
  assign link.ctrl_player   = player_q;

  assign my_turn    = my_turn_q;
  assign can_done   = my_turn_q & rule_valid;
  assign can_draw   = my_turn_q & ~deck_empty_q;
  assign init_phase = init_phase_q;
  assign deck_empty = deck_empty_q;

endmodule

// File: tb/tb_game_turn_ctrl.sv
// Directed bench: seat 0 and seat 1 controllers of a two-player ring, each with its own link.
module tb_game_turn_ctrl;
  localparam int unsigned DS = 106;
  localparam int unsigned IW = $clog2(DS);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic ib_rst0, ib_rst1, start0, start1, done0, done1, draw0, draw1, rv0, rv1;
  logic clr0, clr1;
  logic [DS-1:0] mask0, mask1;
  logic [DS-1:0] taken0 = '0;
  logic [DS-1:0] taken1 = '0;
  logic my0, cd0, cw0, ip0, de0, my1, cd1, cw1, ip1, de1;

  game_turn_ctrl_if #(.DECK_SIZE(DS)) l0 ();
  game_turn_ctrl_if #(.DECK_SIZE(DS)) l1 ();

  game_turn_ctrl #(.NUM_PLAYERS(2), .PLAYER_ID(0), .INIT_DRAW(14), .DECK_SIZE(DS)) dut0 (
    .clk(clk), .rst(rst), .interboard_rst(ib_rst0), .start_game(start0),
    .done_and_next(done0), .draw_and_next(draw0), .rule_valid(rv0),
    .available_card(mask0 & ~taken0), .link(l0),
    .my_turn(my0), .can_done(cd0), .can_draw(cw0), .init_phase(ip0), .deck_empty(de0)
  );

  game_turn_ctrl #(.NUM_PLAYERS(2), .PLAYER_ID(1), .INIT_DRAW(14), .DECK_SIZE(DS)) dut1 (
    .clk(clk), .rst(rst), .interboard_rst(ib_rst1), .start_game(start1),
    .done_and_next(done1), .draw_and_next(draw1), .rule_valid(rv1),
    .available_card(mask1 & ~taken1), .link(l1),
    .my_turn(my1), .can_done(cd1), .can_draw(cw1), .init_phase(ip1), .deck_empty(de1)
  );

  // Message logs; drawn cards leave the deck model straight away.
  int cnt0 = 0;
  int cnt1 = 0;
  logic [3:0]    typ0[$], typ1[$];
  logic [IW-1:0] card0[$], card1[$];
  logic [1:0]    pl0[$], pl1[$];

  always @(negedge clk) begin
    if (clr0) taken0 <= '0;
    else if (l0.ctrl_en && l0.ctrl_msg_type == 4'd5) taken0[l0.ctrl_card] <= 1'b1;
    if (l0.ctrl_en) begin
      typ0.push_back(l0.ctrl_msg_type);
      card0.push_back(l0.ctrl_card);
      pl0.push_back(l0.ctrl_player);
      cnt0 <= cnt0 + 1;
    end
  end

  always @(negedge clk) begin
    if (clr1) taken1 <= '0;
    else if (l1.ctrl_en && l1.ctrl_msg_type == 4'd5) taken1[l1.ctrl_card] <= 1'b1;
    if (l1.ctrl_en) begin
      typ1.push_back(l1.ctrl_msg_type);
      card1.push_back(l1.ctrl_card);
      pl1.push_back(l1.ctrl_player);
      cnt1 <= cnt1 + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_turn(input int which, input logic [1:0] seat);
    if (which == 0) begin
      l0.interboard_en = 1'b1; l0.interboard_msg_type = 4'd6; l0.interboard_player = seat;
    end else begin
      l1.interboard_en = 1'b1; l1.interboard_msg_type = 4'd6; l1.interboard_player = seat;
    end
    step(1);
    l0.interboard_en = 1'b0;
    l1.interboard_en = 1'b0;
    #1;
  endtask

  task automatic wait_cnt(input int which, input int n, input int budget, input string tag);
    int k = 0;
    while (((which == 0) ? cnt0 : cnt1) < n && k < budget) begin
      step(1);
      k++;
    end
    check(tag, 32'((((which == 0) ? cnt0 : cnt1) >= n)), 32'd1);
  endtask

  // First 14 logged messages must be DECK_DRAW with distinct in-range cards,
  // the 15th a STATE_TURN to next_seat.
  task automatic check_deal(input int which, input logic [1:0] next_seat, input string tag);
    int bad = 0;
    int dup = 0;
    logic [3:0]    t;
    logic [IW-1:0] ci, cj;
    for (int i = 0; i < 14; i++) begin
      t  = (which == 0) ? typ0[i] : typ1[i];
      ci = (which == 0) ? card0[i] : card1[i];
      if (t !== 4'd5 || 32'(ci) >= DS) bad++;
      for (int j = i + 1; j < 14; j++) begin
        cj = (which == 0) ? card0[j] : card1[j];
        if (ci === cj) dup++;
      end
    end
    check({tag, "_draw_types"}, 32'(bad), 32'd0);
    check({tag, "_distinct"}, 32'(dup), 32'd0);
    check({tag, "_turn_type"}, 32'((which == 0) ? typ0[14] : typ1[14]), 32'd6);
    check({tag, "_turn_seat"}, 32'((which == 0) ? pl0[14] : pl1[14]), 32'(next_seat));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    rst = 1'b1;
    {ib_rst0, ib_rst1, start0, start1, done0, done1, draw0, draw1, clr0, clr1} = '0;
    rv0 = 1'b1; rv1 = 1'b0;
    mask0 = '1; mask1 = '1;
    l0.interboard_en = 1'b0; l0.interboard_msg_type = '0; l0.interboard_player = '0;
    l1.interboard_en = 1'b0; l1.interboard_msg_type = '0; l1.interboard_player = '0;
    l0.send_ready = 1'b1; l1.send_ready = 1'b1;
    step(3);
    check("rst_my_turn", my0, 0);
    check("rst_can_done", cd0, 0);
    check("rst_can_draw", cw0, 0);
    check("rst_init_phase", ip0, 0);
    check("rst_deck_empty", de0, 0);
    check("rst_ctrl_en", l0.ctrl_en, 0);
    check("rst_msg_type", l0.ctrl_msg_type, 0);
    check("rst_card", l0.ctrl_card, 0);
    rst = 1'b0;
    step(2);

    // Seat 0 deals 14 cards then passes the token to seat 1.
    start0 = 1'b1; step(1); start0 = 1'b0; #1;
    check("p0_init_phase_set", ip0, 1);
    wait_cnt(0, 15, 400, "p0_deal_timeout");
    step(2);
    check_deal(0, 2'd1, "p0_deal");
    check("p0_deal_count", cnt0, 15);
    check("p0_keeps_init_phase", ip0, 1);
    check("p0_wait_not_my_turn", my0, 0);

    // Token returns: seat 0 clears init_phase and takes its turn.
    send_turn(0, 2'd0);
    check("p0_my_turn", my0, 1);
    check("p0_init_cleared", ip0, 0);
    rv0 = 1'b0; #1;
    check("p0_can_done_low", cd0, 0);
    check("p0_can_draw", cw0, 1);

    // done_and_next without rule_valid is ignored.
    done0 = 1'b1; step(1); done0 = 1'b0;
    step(4);
    check("done_invalid_no_msg", cnt0, 15);
    check("done_invalid_stays", my0, 1);
    rv0 = 1'b1; #1;
    check("p0_can_done_high", cd0, 1);
    done0 = 1'b1; step(1); done0 = 1'b0;
    wait_cnt(0, 16, 20, "done_valid_timeout");
    check("done_valid_type", typ0[15], 4'd6);
    check("done_valid_seat", pl0[15], 2'd1);
    check("done_valid_my_turn_drop", my0, 0);

    // Only the top card is left in the deck.
    send_turn(0, 2'd0);
    mask0 = '0; mask0[DS-1] = 1'b1;
    clr0 = 1'b1; step(1); clr0 = 1'b0;
    draw0 = 1'b1; step(1); draw0 = 1'b0;
    wait_cnt(0, 18, 300, "draw_last_timeout");
    check("draw_last_type", typ0[16], 4'd5);
    check("draw_last_card", card0[16], 7'd105);
    check("draw_last_turn_type", typ0[17], 4'd6);
    check("draw_last_turn_seat", pl0[17], 2'd1);
    check("draw_last_not_empty", de0, 0);

    // Empty deck: draw skipped, only STATE_TURN goes out, deck_empty sticks.
    send_turn(0, 2'd0);
    mask0 = '0;
    draw0 = 1'b1; step(1); draw0 = 1'b0;
    wait_cnt(0, 19, 300, "draw_empty_timeout");
    check("draw_empty_type", typ0[18], 4'd6);
    step(5);
    check("draw_empty_one_msg", cnt0, 19);
    check("deck_empty_set", de0, 1);
    send_turn(0, 2'd0);
    check("empty_my_turn", my0, 1);
    check("empty_can_draw_low", cw0, 0);

    // Back-pressure: message held stable with no ctrl_en, then exactly one pulse.
    l0.send_ready = 1'b0;
    done0 = 1'b1; step(1); done0 = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (l0.ctrl_en !== 1'b0 || l0.ctrl_msg_type !== 4'd6 || l0.ctrl_player !== 2'd1) bad++;
    end
    check("hold_stable", bad, 0);
    check("hold_no_msg", cnt0, 19);
    l0.send_ready = 1'b1;
    step(5);
    check("hold_one_pulse", cnt0, 20);
    check("hold_pulse_type", typ0[19], 4'd6);

    // Asynchronous reset while a message waits in EMIT.
    send_turn(0, 2'd0);
    l0.send_ready = 1'b0;
    done0 = 1'b1; step(1); done0 = 1'b0;
    step(2);
    #2 rst = 1'b1;
    #1;
    check("emit_rst_my_turn", my0, 0);
    check("emit_rst_deck_empty", de0, 0);
    check("emit_rst_player", l0.ctrl_player, 0);
    check("emit_rst_msg_type", l0.ctrl_msg_type, 0);
    l0.send_ready = 1'b1; #1;
    check("emit_rst_ctrl_en", l0.ctrl_en, 0);
    step(2);
    rst = 1'b0;
    step(10);
    check("emit_rst_dropped", cnt0, 20);

    // interboard_rst while searching an empty deck during the deal.
    mask0 = '0;
    start0 = 1'b1; step(1); start0 = 1'b0;
    step(130);
    check("search_deck_empty", de0, 1);
    check("search_init_phase", ip0, 1);
    ib_rst0 = 1'b1; step(1); ib_rst0 = 1'b0; #1;
    check("ibrst_deck_empty", de0, 0);
    check("ibrst_init_phase", ip0, 0);
    check("ibrst_my_turn", my0, 0);
    step(200);
    check("ibrst_no_msg", cnt0, 20);
    check("ibrst_idle", ip0, 0);

    // Seat 1: waits for its token, deals, passes to seat 0 and leaves init phase.
    start1 = 1'b1; step(1); start1 = 1'b0; #1;
    check("p1_init_phase_set", ip1, 1);
    check("p1_not_my_turn", my1, 0);
    send_turn(1, 2'd0);
    step(5);
    check("p1_other_seat_ignored", cnt1, 0);
    send_turn(1, 2'd1);
    wait_cnt(1, 15, 400, "p1_deal_timeout");
    step(2);
    check_deal(1, 2'd0, "p1_deal");
    check("p1_init_cleared", ip1, 0);
    check("p1_wait_not_my_turn", my1, 0);
    send_turn(1, 2'd1);
    check("p1_my_turn", my1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_turn_ctrl.md
GAME_TURN_CTRL -- requirements
Module: game_turn_ctrl

Interface
REQ-001 Parameter NUM_PLAYERS, default 2, number of boards in the ring (legal 2..4).
REQ-002 Parameter PLAYER_ID, default 0, this board's seat (0..NUM_PLAYERS-1).
REQ-003 Parameter INIT_DRAW, default 14, cards each player draws at game start.
REQ-004 Parameter DECK_SIZE, default 106, number of physical cards; IW = clog2(DECK_SIZE).
REQ-005 clk  in  1  system clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 interboard_rst  in  1  synchronous game reset from the remote side, same effect as rst.
REQ-008 start_game  in  1  one-cycle pulse; ignored unless in IDLE.
REQ-009 done_and_next / draw_and_next  in  1 each  one-cycle player requests; honoured only in MY_TURN.
REQ-010 rule_valid  in  1  table currently legal; gates done_and_next.
REQ-011 available_card  in  DECK_SIZE  bit i high = card i still in deck.
REQ-012 interboard_en  in  1; interboard_msg_type  in  4; interboard_player  in  2  received message strobe, type, target seat.
REQ-013 send_ready  in  1  link can accept a message this cycle.
REQ-014 ctrl_en  out  1; ctrl_msg_type  out  4; ctrl_card  out  IW; ctrl_player  out  2  outgoing message.
REQ-015 my_turn  out  1; can_done  out  1; can_draw  out  1; init_phase  out  1; deck_empty  out  1 (sticky).

Function
REQ-016 States: IDLE, INIT_DRAW, SEARCH, EMIT, WAIT_TURN, MY_TURN; message types DECK_DRAW=5, STATE_TURN=6.
REQ-017 IDLE: start_game with PLAYER_ID=0 -> INIT_DRAW, init_phase=1; otherwise start_game -> WAIT_TURN, init_phase=1.
REQ-018 WAIT_TURN: interboard_en with type STATE_TURN and interboard_player=PLAYER_ID -> INIT_DRAW if init_phase else MY_TURN; other messages ignored.
REQ-019 Draw: 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 xor PLAYER_ID) advances every cycle; draw start index = LFSR mod DECK_SIZE.
REQ-020 SEARCH tests one index per cycle, incrementing with wrap DECK_SIZE-1 -> 0; first set bit -> EMIT with ctrl_card=index, type DECK_DRAW.
REQ-021 SEARCH visiting DECK_SIZE indices with none set: deck_empty=1, draw skipped, proceeds as if drawn.
REQ-022 EMIT holds message stable; ctrl_en high for exactly the one cycle in which send_ready=1, then advances.
REQ-023 INIT_DRAW: counter draws INIT_DRAW cards via SEARCH/EMIT; after last, emits STATE_TURN to (PLAYER_ID+1) mod NUM_PLAYERS, -> WAIT_TURN.
REQ-024 Last seat (PLAYER_ID=NUM_PLAYERS-1) clears init_phase after its init draws; seat 0 clears init_phase on receiving its STATE_TURN; all others clear on completing init draw.
REQ-025 MY_TURN: my_turn=1; can_done=rule_valid; can_draw=~deck_empty.
REQ-026 done_and_next with rule_valid -> emit STATE_TURN to next seat -> WAIT_TURN; without rule_valid ignored.
REQ-027 draw_and_next -> one draw (REQ-020) then STATE_TURN to next seat; both requests same cycle: draw_and_next wins.
REQ-028 Requests outside MY_TURN, or while EMIT pending, ignored; no queuing.
REQ-029 available_card sampled live during SEARCH; caller guarantees it is updated within 1 cycle of a DECK_DRAW emission.

Reset
REQ-030 rst or interboard_rst: state IDLE, all outputs 0, counters 0, deck_empty 0, init_phase 0, LFSR to seed; reset mid-EMIT drops the message with no ctrl_en.

Structure
REQ-031 Message-type codes, state encoding and LFSR seed belong in the shared game package used by the other game-control blocks.
REQ-032 Card search is a sub-module deck_picker (start index, available vector, go -> found, index, empty, done).

Verification
REQ-033 2 players, PLAYER_ID=0, all cards available, send_ready=1, start_game -> 14 ctrl_en DECK_DRAW pulses, distinct indices, then STATE_TURN with ctrl_player=1.
REQ-034 PLAYER_ID=1 in WAIT_TURN, STATE_TURN to 1 received -> 14 draws, STATE_TURN to 0, init_phase=0.
REQ-035 MY_TURN, available_card only bit 105 set -> draw_and_next yields ctrl_card=105 then STATE_TURN; all zero -> deck_empty=1, only STATE_TURN sent.
REQ-036 MY_TURN, rule_valid=0, done_and_next -> no ctrl_en, stays MY_TURN; rule_valid=1 -> STATE_TURN, my_turn drops.
REQ-037 EMIT with send_ready low 20 cycles -> message stable, no ctrl_en; send_ready high -> exactly one ctrl_en.
REQ-038 rst asserted mid-EMIT and mid-SEARCH -> immediate IDLE, all outputs 0, no ctrl_en after release.
